// File: rtl/rsa_addsub.sv
// rsa_addsub: registered N-bit ripple-carry adder/subtractor, Cin=0 add, Cin=1 subtract
module rsa_addsub #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  input  logic         in_valid,
  output logic [N-1:0] Sum,
  output logic         Cout,
  output logic         out_valid
);
  logic [N-1:0] bb, s;
  logic [N:0]   c;
  assign c[0] = Cin;
  for (genvar i = 0; i < N; i++) begin : g_fa
    assign bb[i]   = B[i] ^ Cin;
    assign s[i]    = A[i] ^ bb[i] ^ c[i];
    assign c[i+1]  = (A[i] & bb[i]) | (c[i] & (A[i] ^ bb[i]));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Sum       <= '0;
      Cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Sum  <= s;
        Cout <= c[N];
      end
    end
  end
endmodule

// File: tb/tb_rsa_addsub.sv
// tb_rsa_addsub: table, random and corner-case checks of rsa_addsub against an arithmetic model
module tb_rsa_addsub;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a, b;
  logic       cin, in_valid;
  logic [7:0] sum;
  logic       cout, out_valid;
  int n_chk = 0;
  int n_fail = 0;

  rsa_addsub #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n), .A(a), .B(b), .Cin(cin), .in_valid(in_valid),
    .Sum(sum), .Cout(cout), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] ref_op(input logic [7:0] x, input logic [7:0] y, input logic c);
    int t;
    logic [7:0] d;
    if (c) begin
      d = x - y;
      return {(x >= y), d};
    end
    t = int'(x) + int'(y);
    return {(t > 255), t[7:0]};
  endfunction

  task automatic drive(input logic [7:0] x, input logic [7:0] y, input logic c, input logic v);
    a = x; b = y; cin = c; in_valid = v;
  endtask

  initial begin
    logic [8:0]  r;
    logic [7:0]  hs;
    logic        hc;
    logic        v;
    logic [7:0]  x, y;
    logic        c;
    vecs[0] = '{8'd1,  8'd1,  1'b1, 8'd0,   1'b1};
    vecs[1] = '{8'd2,  8'd2,  1'b1, 8'd0,   1'b1};
    vecs[2] = '{8'd8,  8'd3,  1'b1, 8'd5,   1'b1};
    vecs[3] = '{8'd15, 8'd15, 1'b1, 8'd0,   1'b1};
    vecs[4] = '{8'd56, 8'd25, 1'b1, 8'd31,  1'b1};
    vecs[5] = '{8'd1,  8'd15, 1'b0, 8'd16,  1'b0};
    vecs[6] = '{8'd255,8'd1,  1'b0, 8'd0,   1'b1};
    vecs[7] = '{8'd0,  8'd1,  1'b1, 8'hFF,  1'b0};
    vecs[8] = '{8'd8,  8'd12, 1'b1, 8'hFC,  1'b0};
    rst_n = 1'b0;
    drive(8'd0, 8'd0, 1'b0, 1'b0);
    #3;
    chk("reset_sum", 32'(sum), 32'd0);
    chk("reset_cout", 32'(cout), 32'd0);
    chk("reset_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    foreach (vecs[i]) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b1);
      @(negedge clk);
      chk($sformatf("vec%0d_sum", i), 32'(sum), 32'(vecs[i].sum));
      chk($sformatf("vec%0d_cout", i), 32'(cout), 32'(vecs[i].cout));
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
    end
    hs = sum;
    hc = cout;
    for (int i = 0; i < 6; i++) begin
      v = i[0] ? 1'b0 : 1'b1;
      x = 8'(20 + i * 7);
      y = 8'(3 * i);
      if (v) drive(x, y, i[1], 1'b1);
      else drive('x, 'x, 1'bx, 1'b0);
      @(negedge clk);
      if (v) begin
        r = ref_op(x, y, i[1]);
        hs = r[7:0];
        hc = r[8];
      end
      chk("alt_valid", 32'(out_valid), 32'(v));
      chk("alt_sum", 32'(sum), 32'(hs));
      chk("alt_cout", 32'(cout), 32'(hc));
    end
    for (int i = 0; i < 300; i++) begin
      v = ($urandom_range(0, 3) != 0);
      x = 8'($urandom);
      y = 8'($urandom);
      c = 1'($urandom);
      if (v) drive(x, y, c, 1'b1);
      else drive('x, 'x, 1'bx, 1'b0);
      @(negedge clk);
      if (v) begin
        r = ref_op(x, y, c);
        hs = r[7:0];
        hc = r[8];
      end
      chk("rnd_valid", 32'(out_valid), 32'(v));
      chk("rnd_sum", 32'(sum), 32'(hs));
      chk("rnd_cout", 32'(cout), 32'(hc));
    end
    drive(8'd200, 8'd100, 1'b0, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_cout", 32'(cout), 32'd0);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("inrst_valid", 32'(out_valid), 32'd0);
    chk("inrst_sum", 32'(sum), 32'd0);
    rst_n = 1'b1;
    drive(8'd9, 8'd200, 1'b1, 1'b1);
    @(negedge clk);
    chk("postrst_sum", 32'(sum), 32'(8'd65));
    chk("postrst_cout", 32'(cout), 32'd0);
    chk("postrst_valid", 32'(out_valid), 32'd1);
    drive('x, 'x, 1'bx, 1'b0);
    @(negedge clk);
    chk("postrst_hold_valid", 32'(out_valid), 32'd0);
    chk("postrst_hold_sum", 32'(sum), 32'(8'd65));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
